// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/MEM requester and memory-side signals of the port arbiter
interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] m_rdata;
  logic        m_done;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        if_stall;
  logic        mem_stall;
  logic        err;
  modport master (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, m_rdata, m_done,
    output m_addr, m_wdata, m_rd, m_wr, if_rdata, if_valid, mem_rdata, mem_valid,
           if_stall, mem_stall, err
  );
  modport slave (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, m_rdata, m_done,
    input  m_addr, m_wdata, m_rd, m_wr, if_rdata, if_valid, mem_rdata, mem_valid,
           if_stall, mem_stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and MEM (MEM first); ARB_PERF_EN adds a stall-cycle counter
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.master bus
`ifdef ARB_PERF_EN
  ,
  output logic [15:0] perf_stall_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY_MEM, BUSY_IF, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic        m_rd_q, m_rd_d, m_wr_q, m_wr_d;
  logic        if_valid_q, if_valid_d, mem_valid_q, mem_valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  // Next state: grant in IDLE, wait for done or timeout in BUSY, one-cycle valid in DONE
  always_comb begin
    state_d     = state_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_rd_d      = m_rd_q;
    m_wr_d      = m_wr_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    err_d       = err_q;
    cnt_d       = '0;
    case (state_q)
      IDLE: begin
        if (bus.mem_rd | bus.mem_wr) begin
          state_d   = BUSY_MEM;
          m_addr_d  = bus.mem_addr;
          m_wdata_d = bus.mem_wdata;
          m_wr_d    = bus.mem_wr;
          m_rd_d    = bus.mem_rd & ~bus.mem_wr;
        end else if (bus.if_req) begin
          state_d  = BUSY_IF;
          m_addr_d = bus.if_addr;
          m_rd_d   = 1'b1;
          m_wr_d   = 1'b0;
        end
      end
      BUSY_MEM, BUSY_IF: begin
        if (bus.m_done) begin
          state_d = DONE;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
          if (state_q == BUSY_IF) begin
            if_rdata_d = bus.m_rdata;
            if_valid_d = 1'b1;
          end else begin
            mem_rdata_d = m_rd_q ? bus.m_rdata : mem_rdata_q;
            mem_valid_d = 1'b1;
          end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = IDLE;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_rd_q      <= 1'b0;
      m_wr_q      <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_rd_q      <= m_rd_d;
      m_wr_q      <= m_wr_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_rd      = m_rd_q;
  assign bus.m_wr      = m_wr_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.err       = err_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.mem_stall = (bus.mem_rd | bus.mem_wr) & ~mem_valid_q;
`ifdef ARB_PERF_EN
  logic [15:0] perf_q, perf_d;
  // Saturating count of cycles with either pipeline stage stalled
  always_comb perf_d = ((bus.if_stall | bus.mem_stall) && perf_q != 16'hFFFF) ? perf_q + 16'd1 : perf_q;
  // Counter register
  always_ff @(posedge clk) perf_q <= !rst_n ? 16'd0 : perf_d;
  assign perf_stall_cycles = perf_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (default and TIMEOUT=4 instances)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if b();
  mem_port_arbiter_if t();
`ifdef ARB_PERF_EN
  logic [15:0] perf_b, perf_t;
`endif
  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
`ifdef ARB_PERF_EN
    , .perf_stall_cycles(perf_b)
`endif
  );
  mem_port_arbiter #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(t)
`ifdef ARB_PERF_EN
    , .perf_stall_cycles(perf_t)
`endif
  );
  typedef struct {
    logic        is_if;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_ifv = 0;
  int n_memv = 0;
  int n_tv = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic is_if, input logic [15:0] data);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    q.push_back(e);
  endtask
  task automatic monitor();
    exp_t e;
    if (b.if_valid) begin
      n_ifv++;
      chk("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_src_if", 32'(e.is_if), 1);
        chk("if_rdata", b.if_rdata, e.data);
      end
    end
    if (b.mem_valid) begin
      n_memv++;
      chk("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_src_mem", 32'(e.is_if), 0);
        chk("mem_rdata", b.mem_rdata, e.data);
      end
    end
    if (t.if_valid | t.mem_valid) n_tv++;
  endtask
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int memv0;
    b.if_req = 1'b1; b.if_addr = '0; b.mem_rd = 1'b0; b.mem_wr = 1'b0;
    b.mem_addr = '0; b.mem_wdata = '0; b.m_rdata = '0; b.m_done = 1'b0;
    t.if_req = 1'b0; t.if_addr = '0; t.mem_rd = 1'b0; t.mem_wr = 1'b0;
    t.mem_addr = '0; t.mem_wdata = '0; t.m_rdata = '0; t.m_done = 1'b0;
    tick();
    tick();
    chk("rst_m_rd", b.m_rd, 0);
    chk("rst_m_wr", b.m_wr, 0);
    chk("rst_m_addr", b.m_addr, 0);
    chk("rst_m_wdata", b.m_wdata, 0);
    chk("rst_if_rdata", b.if_rdata, 0);
    chk("rst_mem_rdata", b.mem_rdata, 0);
    chk("rst_valids", {b.if_valid, b.mem_valid}, 0);
    chk("rst_err", b.err, 0);
    chk("rst_if_stall", b.if_stall, 1);
    chk("rst_mem_stall", b.mem_stall, 0);
`ifdef ARB_PERF_EN
    chk("rst_perf", perf_b, 0);
`endif
    b.if_req = 1'b0;
    rst_n = 1'b1;
    tick();
    // IF read, done in first busy cycle
    b.if_req = 1'b1; b.if_addr = 16'h0040;
    push(1'b1, 16'hA5C3);
    #1 chk("if_stall_c0", b.if_stall, 1);
    tick();
    chk("if_m_rd_c1", b.m_rd, 1);
    chk("if_m_addr_c1", b.m_addr, 16'h0040);
    chk("if_m_wr_c1", b.m_wr, 0);
    b.m_done = 1'b1; b.m_rdata = 16'hA5C3;
    tick();
    b.m_done = 1'b0;
    #1 chk("if_valid_c2", b.if_valid, 1);
    chk("if_stall_c2", b.if_stall, 0);
    chk("if_m_rd_c2", b.m_rd, 0);
    b.if_req = 1'b0;
    tick();
    chk("if_valid_c3", b.if_valid, 0);
    // simultaneous IF and MEM load: MEM first
    b.if_req = 1'b1; b.if_addr = 16'h0080;
    b.mem_rd = 1'b1; b.mem_addr = 16'h1000;
    push(1'b0, 16'hBEEF);
    push(1'b1, 16'h7777);
    tick();
    chk("arb_m_addr", b.m_addr, 16'h1000);
    chk("arb_m_rd", b.m_rd, 1);
    chk("arb_stalls", {b.if_stall, b.mem_stall}, 2'b11);
    b.m_done = 1'b1; b.m_rdata = 16'hBEEF;
    tick();
    b.m_done = 1'b0;
    #1 chk("arb_mem_valid", b.mem_valid, 1);
    chk("arb_stalls_done", {b.if_stall, b.mem_stall}, 2'b10);
    b.mem_rd = 1'b0;
    tick();
    chk("arb_idle_strobe", b.m_rd, 0);
    tick();
    chk("arb_if_m_rd", b.m_rd, 1);
    chk("arb_if_m_addr", b.m_addr, 16'h0080);
    b.m_done = 1'b1; b.m_rdata = 16'h7777;
    tick();
    b.m_done = 1'b0;
    #1 chk("arb_if_valid", b.if_valid, 1);
    b.if_req = 1'b0;
    tick();
    // store with done delayed 4 cycles, mem_rdata must stay BEEF
    memv0 = n_memv;
    b.mem_wr = 1'b1; b.mem_addr = 16'h2000; b.mem_wdata = 16'h1234;
    push(1'b0, 16'hBEEF);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("st_m_wr_c%0d", i), b.m_wr, 1);
      chk($sformatf("st_m_rd_c%0d", i), b.m_rd, 0);
      if (i == 5) b.m_done = 1'b1;
    end
    chk("st_m_wdata", b.m_wdata, 16'h1234);
    chk("st_m_addr", b.m_addr, 16'h2000);
    tick();
    b.m_done = 1'b0;
    b.mem_wr = 1'b0;
    chk("st_m_wr_done", b.m_wr, 0);
    tick();
    tick();
    chk("st_one_valid", n_memv - memv0, 1);
    // read+write together is a write
    b.mem_rd = 1'b1; b.mem_wr = 1'b1; b.mem_addr = 16'h3000; b.mem_wdata = 16'h5555;
    push(1'b0, 16'hBEEF);
    tick();
    chk("rw_m_wr", b.m_wr, 1);
    chk("rw_m_rd", b.m_rd, 0);
    b.m_done = 1'b1; b.m_rdata = 16'hDEAD;
    tick();
    b.m_done = 1'b0; b.mem_rd = 1'b0; b.mem_wr = 1'b0;
    tick();
    // timeout on the TIMEOUT=4 instance
    t.mem_rd = 1'b1; t.mem_addr = 16'h0010;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_m_rd_c%0d", i), t.m_rd, 1);
      chk($sformatf("to_err_c%0d", i), t.err, 0);
    end
    tick();
    t.mem_rd = 1'b0;
    chk("to_m_rd_drop", t.m_rd, 0);
    chk("to_err_set", t.err, 1);
    tick();
    t.m_done = 1'b1;
    tick();
    t.m_done = 1'b0;
    tick();
    tick();
    chk("to_err_sticky", t.err, 1);
    chk("to_no_valid", n_tv, 0);
    chk("to_idle_strobes", {t.m_rd, t.m_wr}, 0);
    // reset in the middle of an IF access
    b.if_req = 1'b1; b.if_addr = 16'h0050;
    tick();
    chk("rb_m_rd", b.m_rd, 1);
    rst_n = 1'b0;
    tick();
    chk("rb_m_rd_reset", b.m_rd, 0);
    chk("rb_to_err_cleared", t.err, 0);
`ifdef ARB_PERF_EN
    chk("rb_perf_zero", perf_b, 0);
`endif
    rst_n = 1'b1; b.if_req = 1'b0; b.m_done = 1'b1;
    tick();
    b.m_done = 1'b0;
    chk("rb_no_valid", b.if_valid, 0);
    chk("rb_strobes", {b.m_rd, b.m_wr}, 0);
    tick();
    chk("rb_no_valid2", b.if_valid, 0);
`ifdef ARB_PERF_EN
    chk("rb_perf_idle", perf_b, 0);
`endif
    // one more fetch after reset; two stall cycles expected
    b.if_req = 1'b1; b.if_addr = 16'h0060;
    push(1'b1, 16'h0F0F);
    tick();
    b.m_done = 1'b1; b.m_rdata = 16'h0F0F;
    tick();
    b.m_done = 1'b0;
    b.if_req = 1'b0;
    tick();
`ifdef ARB_PERF_EN
    chk("perf_count", perf_b, 2);
`endif
    tick();
    chk("sb_drained", q.size(), 0);
    chk("if_valid_total", n_ifv, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the single-ported unified memory between the fetch stage (IF) and the memory stage (MEM) of the 5-stage 16-bit pipeline. It launches one access at a time, waits for the memory's done pulse, returns read data, and drives `if_stall` and `mem_stall`. These two signals are ORed into the pipeline's existing stall/`pcWrite`/`ifid_write` controls, so the pipeline freezes while an access is outstanding. MEM has priority over IF, since the MEM instruction is older.

## Interface
- `TIMEOUT`, default 64: cycles in a busy state before abort; legal range 2..255.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `if_req`  in  1  fetch request, held until `if_valid`.
- `if_addr`  in  16  fetch address.
- `mem_rd`  in  1  MEM-stage load request, held until `mem_valid`.
- `mem_wr`  in  1  MEM-stage store request, held until `mem_valid`.
- `mem_addr`  in  16  load/store address.
- `mem_wdata`  in  16  store data.
- `m_rdata`  in  16  memory read data, valid with `m_done`.
- `m_done`  in  1  one-cycle pulse: current access complete.
- `m_addr`  out  16  registered memory address.
- `m_wdata`  out  16  registered memory write data.
- `m_rd`  out  1  memory read strobe; level, held through the access.
- `m_wr`  out  1  memory write strobe; level, held through the access.
- `if_rdata`  out  16  registered instruction word.
- `if_valid`  out  1  one-cycle pulse: fetch complete.
- `mem_rdata`  out  16  registered load data.
- `mem_valid`  out  1  one-cycle pulse: load/store complete.
- `if_stall`  out  1  combinational: `if_req & ~if_valid`.
- `mem_stall`  out  1  combinational: `(mem_rd|mem_wr) & ~mem_valid`.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY_MEM, BUSY_IF, DONE.
- IDLE:
  - `mem_rd|mem_wr` → BUSY_MEM.
  - Otherwise `if_req` → BUSY_IF.
  - Otherwise stay in IDLE.
  - On entry to a BUSY state, `m_addr`, `m_wdata`, `m_rd` and `m_wr` are captured from the selected requester.
- Simultaneous IF and MEM requests in IDLE: MEM is granted; IF waits (its stall stays high).
- `mem_rd & mem_wr` both high: treated as a write (`m_wr=1`, `m_rd=0`).
- BUSY_x: strobes are held constant.
  - `m_done=1` → DONE. For a read, `m_rdata` is captured into `if_rdata` or `mem_rdata`. A write leaves `mem_rdata` unchanged.
  - Timeout counter increments each cycle in BUSY. When it reaches `TIMEOUT` without `m_done`: set `err`, deassert strobes, go to IDLE, no valid pulse.
- DONE: exactly one cycle.
  - `if_valid` or `mem_valid` = 1 for the granted requester.
  - Strobes are 0.
  - Requests are ignored this cycle, so a held request is never relaunched. Next state is IDLE.
- `m_done` outside a BUSY state is ignored.
- `err` is cleared only by reset.
- Reset values: state IDLE; `m_addr`, `m_wdata`, `if_rdata`, `mem_rdata` = 0; `m_rd`, `m_wr`, `if_valid`, `mem_valid`, `err` = 0; timeout counter = 0. The combinational stalls follow their inputs.
- Reset mid-access: strobes drop at that edge; a later `m_done` for the aborted access is ignored.

## Timing
- Request seen in IDLE at cycle 0 → strobe high in cycle 1 → earliest `m_done` in cycle 1 → DONE/valid in cycle 2 → IDLE in cycle 3.
- Minimum 3 cycles per access; each `m_done` wait cycle adds 1.
- Back-to-back: a MEM access completing at cycle N while IF is pending → IF launches from IDLE at cycle N+1; IF strobe high at N+2.
- Stalls stay high from request assertion through the cycle before valid. They are low in the valid cycle, so the pipeline advances on that edge.

## Configuration
- `ARB_PERF_EN` defined: adds output `perf_stall_cycles` [15:0].
  - Increments every cycle in which `if_stall|mem_stall` is high.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with `rst_n=0` for 2 cycles → all outputs 0, state IDLE; with `if_req=1`, `if_stall=1`.
- IF read at `if_addr=16'h0040`, `m_done` in cycle 1 with `m_rdata=16'hA5C3` → `m_rd=1` in cycle 1, `if_valid=1` and `if_rdata=16'hA5C3` in cycle 2, `if_stall=0` in cycle 2.
- `if_req` and `mem_rd` (`mem_addr=16'h1000`) asserted together → `m_addr=16'h1000` first; `mem_valid` pulses; IF strobe follows one cycle after DONE.
- Store `mem_wr=1`, `mem_wdata=16'h1234`, `m_done` delayed 4 cycles → `m_wr` held 5 cycles; `mem_valid` pulses once; `mem_rdata` unchanged.
- `TIMEOUT=4` with no `m_done` → strobes drop after 4 busy cycles; `err=1` sticky; no valid pulse.
- Assert `rst_n=0` mid-BUSY, then pulse `m_done` → no valid pulse, strobes 0. With `ARB_PERF_EN`, `perf_stall_cycles` is 0 after reset and counts subsequent stall cycles exactly.
